// File: rtl/anabellek_yanitlayici.sv
// Responder end of the iomem valid/ready word bus: word-organised main memory with
// byte-strobe writes, BEKLEME wait states and an out-of-range error flag.
// Optional sequential fast path: define ANABELLEK_ARDISIK_HIZLI_EN.
module anabellek_yanitlayici #(
  parameter int unsigned DERINLIK    = 1024,
  parameter logic [31:0] TABAN_ADRES = 32'h4000_0000,
  parameter int unsigned BEKLEME     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iomem_valid_i,
  input  logic [31:0] adres_i,
  input  logic [31:0] yaz_veri_i,
  input  logic [3:0]  wr_strb_i,
  output logic        iomem_ready_o,
  output logic [31:0] okunan_veri_o,
  output logic        hata_o
);

  localparam int unsigned AW        = $clog2(DERINLIK);
  localparam logic [3:0]  BEKLEME_S = 4'(BEKLEME);

  typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;

  durum_t      durum_q;
  logic [3:0]  sayac_q;
  logic [31:0] adres_q;
  logic [31:0] veri_q;
  logic [3:0]  strb_q;
  logic        ready_q;
  logic        hata_q;
  logic [31:0] okunan_q;

  logic [31:0] bellek [DERINLIK];

  logic [31:0] erisimAdres;
  logic [31:0] erisimVeri;
  logic [3:0]  erisimStrb;
  logic [31:0] indeks;
  logic        aralikta;
  logic        kisaYol;
  logic        yanitaGec;

`ifdef ANABELLEK_ARDISIK_HIZLI_EN
  logic [31:0] sonIndeks_q;
  logic        sonYaz_q;
  logic        sonGecerli_q;
`endif

  // A beat that goes straight from BOSTA to YANIT uses the live bus fields,
  // otherwise the fields latched at accept time.
  always_comb begin
    erisimAdres = (durum_q == BOSTA) ? adres_i    : adres_q;
    erisimVeri  = (durum_q == BOSTA) ? yaz_veri_i : veri_q;
    erisimStrb  = (durum_q == BOSTA) ? wr_strb_i  : strb_q;
    indeks      = (erisimAdres - TABAN_ADRES) >> 2;
    aralikta    = (indeks < 32'(DERINLIK));
`ifdef ANABELLEK_ARDISIK_HIZLI_EN
    kisaYol     = (BEKLEME_S == 4'd0) ||
                  (sonGecerli_q && (sonYaz_q == (wr_strb_i != 4'b0000)) &&
                   (indeks == sonIndeks_q + 32'd1));
`else
    kisaYol     = (BEKLEME_S == 4'd0);
`endif
    yanitaGec   = 1'b0;
    case (durum_q)
      BOSTA:   yanitaGec = iomem_valid_i && kisaYol;
      BEKLE:   yanitaGec = iomem_valid_i && (sayac_q == 4'd1);
      default: yanitaGec = 1'b0;
    endcase
  end

  // Storage is not reset; the rst_i gate keeps a beat from landing while reset is held.
  always_ff @(posedge clk_i) begin
    if (yanitaGec && rst_i && aralikta) begin
      for (int i = 0; i < 4; i++) begin
        if (erisimStrb[i]) begin
          bellek[indeks[AW-1:0]][8*i +: 8] <= erisimVeri[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q      <= BOSTA;
      sayac_q      <= 4'd0;
      adres_q      <= 32'd0;
      veri_q       <= 32'd0;
      strb_q       <= 4'd0;
      ready_q      <= 1'b0;
      hata_q       <= 1'b0;
      okunan_q     <= 32'd0;
`ifdef ANABELLEK_ARDISIK_HIZLI_EN
      sonIndeks_q  <= 32'd0;
      sonYaz_q     <= 1'b0;
      sonGecerli_q <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
      hata_q  <= 1'b0;
      case (durum_q)
        BOSTA: begin
          if (iomem_valid_i) begin
            adres_q <= adres_i;
            veri_q  <= yaz_veri_i;
            strb_q  <= wr_strb_i;
            sayac_q <= BEKLEME_S;
            durum_q <= yanitaGec ? YANIT : BEKLE;
`ifdef ANABELLEK_ARDISIK_HIZLI_EN
            sonGecerli_q <= 1'b0;
`endif
          end
        end
        BEKLE: begin
          if (!iomem_valid_i) begin
            sayac_q <= 4'd0;
            durum_q <= BOSTA;
`ifdef ANABELLEK_ARDISIK_HIZLI_EN
            sonGecerli_q <= 1'b0;
`endif
          end else begin
            sayac_q <= sayac_q - 4'd1;
            if (sayac_q == 4'd1) durum_q <= YANIT;
          end
        end
        default: durum_q <= BOSTA;
      endcase
      // Completion edge: respond, load read data and remember the beat.
      if (yanitaGec) begin
        ready_q <= 1'b1;
        hata_q  <= !aralikta;
        if (erisimStrb == 4'b0000) begin
          okunan_q <= aralikta ? bellek[indeks[AW-1:0]] : 32'd0;
        end
`ifdef ANABELLEK_ARDISIK_HIZLI_EN
        sonIndeks_q  <= indeks;
        sonYaz_q     <= (erisimStrb != 4'b0000);
        sonGecerli_q <= 1'b1;
`endif
      end
    end
  end

  assign iomem_ready_o = ready_q;
  assign okunan_veri_o = okunan_q;
  assign hata_o        = hata_q;

endmodule

// File: tb/tb_anabellek_yanitlayici.sv
// Scoreboard bench for anabellek_yanitlayici: directed beats push expectations,
// checkOutput pops them when the ready pulse arrives.
module tb_anabellek_yanitlayici;

  localparam int unsigned BEKLEME = 2;
  localparam int unsigned DERIN   = 1024;
  localparam logic [31:0] TABAN   = 32'h4000_0000;
  localparam int          LIMIT   = 40;
`ifdef ANABELLEK_ARDISIK_HIZLI_EN
  localparam bit HIZLI = 1'b1;
`else
  localparam bit HIZLI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] adres = 32'd0;
  logic [31:0] yazVeri = 32'd0;
  logic [3:0]  strb = 4'd0;
  logic        ready;
  logic [31:0] okunan;
  logic        hata;

  anabellek_yanitlayici #(
    .DERINLIK(DERIN), .TABAN_ADRES(TABAN), .BEKLEME(BEKLEME)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .iomem_valid_i(valid), .adres_i(adres),
    .yaz_veri_i(yazVeri), .wr_strb_i(strb), .iomem_ready_o(ready),
    .okunan_veri_o(okunan), .hata_o(hata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] veri;
    logic        hata;
    int          gecikme;
  } beklenti_t;

  beklenti_t   kuyruk[$];
  int          karsilastirma = 0;
  int          hatalar = 0;
  logic [31:0] modelBellek [logic [31:0]];
  logic [31:0] sonOkunan = 32'd0;
  bit          kayitGecerli = 1'b0;
  bit          kayitYaz = 1'b0;
  logic [31:0] kayitIndeks = 32'd0;

  task automatic kontrol(input string ad, input logic [31:0] gor, input logic [31:0] bek);
    karsilastirma++;
    assert (gor === bek) else begin
      hatalar++;
      $error("[TB] FAIL %s: observed %h expected %h", ad, gor, bek);
    end
  endtask

  // Drives one beat and pushes what the bus should answer; ardisik marks a beat
  // issued in the same cycle the previous ready was seen.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input bit ardisik);
    logic [31:0] idx;
    bit          inr, yaz, hizli;
    beklenti_t   b;
    idx   = (a - TABAN) >> 2;
    inr   = (idx < 32'(DERIN));
    yaz   = (s != 4'b0000);
    hizli = HIZLI && kayitGecerli && (kayitYaz == yaz) && (idx == kayitIndeks + 32'd1);
    if (yaz && inr) begin
      logic [31:0] w;
      w = modelBellek.exists(idx) ? modelBellek[idx] : 32'd0;
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      modelBellek[idx] = w;
    end else if (!yaz) begin
      sonOkunan = inr ? modelBellek[idx] : 32'd0;
    end
    b.veri    = sonOkunan;
    b.hata    = !inr;
    b.gecikme = ((hizli || BEKLEME == 0) ? 1 : 1 + int'(BEKLEME)) + (ardisik ? 1 : 0);
    kuyruk.push_back(b);
    kayitGecerli = 1'b1;
    kayitYaz     = yaz;
    kayitIndeks  = idx;
    valid   = 1'b1;
    adres   = a;
    yazVeri = d;
    strb    = s;
  endtask

  task automatic checkOutput(input string ad);
    beklenti_t b;
    int        n;
    b = kuyruk.pop_front();
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < LIMIT);
    kontrol({ad, " latency"}, n, b.gecikme);
    kontrol({ad, " data"}, okunan, b.veri);
    kontrol({ad, " hata"}, {31'd0, hata}, {31'd0, b.hata});
  endtask

  // Releases the bus and confirms the ready pulse lasted a single cycle.
  task automatic bosta(input string ad);
    valid = 1'b0;
    @(posedge clk); #1;
    kontrol({ad, " ready pulse"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    kontrol("reset ready", {31'd0, ready}, 32'd0);
    kontrol("reset data", okunan, 32'd0);
    kontrol("reset hata", {31'd0, hata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(32'h4000_0000, 32'hCAFE_F00D, 4'b1111, 1'b0); checkOutput("wr0");  bosta("wr0");
    applyStimulus(32'h4000_0000, 32'h0, 4'b0000, 1'b0);         checkOutput("rd0");  bosta("rd0");

    applyStimulus(32'h4000_0010, 32'hA1B2_C3D4, 4'b1111, 1'b0); checkOutput("wr10a"); bosta("wr10a");
    applyStimulus(32'h4000_0010, 32'h5566_7788, 4'b0101, 1'b0); checkOutput("wr10b"); bosta("wr10b");
    applyStimulus(32'h4000_0010, 32'h0, 4'b0000, 1'b0);         checkOutput("rd10");
    kontrol("rd10 merged", okunan, 32'hA166_C388);
    bosta("rd10");

    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h4000_0100 + 32'(4 * k), 32'h1000_0000 + 32'(k * 32'h0101_0101), 4'b1111, 1'b0);
      checkOutput("burst wr");
      bosta("burst wr");
    end
    applyStimulus(32'h4000_0100, 32'h0, 4'b0000, 1'b0);
    checkOutput("burst rd0");
    for (int k = 1; k < 4; k++) begin
      applyStimulus(32'h4000_0100 + 32'(4 * k), 32'h0, 4'b0000, 1'b1);
      checkOutput("burst rd");
    end
    bosta("burst rd");

    applyStimulus(32'h4000_1000, 32'h0, 4'b0000, 1'b0);         checkOutput("oor hi");  bosta("oor hi");
    applyStimulus(32'h3FFF_FFFC, 32'h0, 4'b0000, 1'b0);         checkOutput("oor lo");  bosta("oor lo");
    applyStimulus(32'h4000_1000, 32'hFFFF_FFFF, 4'b1111, 1'b0); checkOutput("oor wr");  bosta("oor wr");
    applyStimulus(32'h4000_0030, 32'h1357_9BDF, 4'b1111, 1'b0); checkOutput("wr30");    bosta("wr30");
    applyStimulus(32'h4000_0030, 32'h0, 4'b0000, 1'b0);         checkOutput("rd30");    bosta("rd30");
    applyStimulus(32'h4000_0000, 32'h0, 4'b0000, 1'b0);         checkOutput("rd0 again"); bosta("rd0 again");

    // Abort: valid dropped one cycle after acceptance leaves the word untouched.
    applyStimulus(32'h4000_0020, 32'h1122_3344, 4'b1111, 1'b0); checkOutput("wr20"); bosta("wr20");
    valid = 1'b1; adres = 32'h4000_0020; yazVeri = 32'h9999_9999; strb = 4'b1111;
    @(posedge clk); #1;
    valid = 1'b0;
    kayitGecerli = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      kontrol("abort no ready", {31'd0, ready}, 32'd0);
    end
    applyStimulus(32'h4000_0020, 32'h0, 4'b0000, 1'b0); checkOutput("rd20 after abort"); bosta("rd20 after abort");

    // Reset in the middle of a pending write discards it.
    valid = 1'b1; adres = 32'h4000_0020; yazVeri = 32'hDEAD_BEEF; strb = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    kontrol("midreset ready", {31'd0, ready}, 32'd0);
    kontrol("midreset data", okunan, 32'd0);
    valid = 1'b0;
    sonOkunan = 32'd0;
    kayitGecerli = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      kontrol("held reset ready", {31'd0, ready}, 32'd0);
    end
    rst_n = 1'b1;
    applyStimulus(32'h4000_0020, 32'h0, 4'b0000, 1'b0); checkOutput("rd20 after reset"); bosta("rd20 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", karsilastirma, hatalar);
    $finish;
  end

endmodule
